// File: rtl/sram_pkg.sv
// Shared SRAM geometry, arbiter FSM encoding and the write-request record
// carried through the write FIFO.
package sram_pkg;

    localparam int SRAM_ADDR_COUNT = 20;
    localparam int SRAM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TURN
    } sram_arb_state_t;

    typedef struct packed {
        logic [SRAM_ADDR_COUNT-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] data;
    } sram_wr_req_t;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client-side bundle of the SRAM arbiter: decoder read port, encoder write
// port, blanking indication and status. slave = arbiter, master = clients.
interface sram_port_arbiter_if
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_COUNT,
    parameter int DATA_W      = SRAM_DATA_WIDTH,
    parameter int WFIFO_DEPTH = 8
);
    localparam int LVL_W = level_width(WFIFO_DEPTH);

    logic              i_frame_blank;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_gnt;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_data_valid;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic [LVL_W-1:0]  o_wfifo_level;
    logic              o_starve;

    modport slave (
        input  i_frame_blank, i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
        output o_rd_gnt, o_rd_data, o_rd_data_valid, o_wr_ready, o_wfifo_level, o_starve
    );

    modport master (
        output i_frame_blank, i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
        input  o_rd_gnt, o_rd_data, o_rd_data_valid, o_wr_ready, o_wfifo_level, o_starve
    );

endinterface

// File: rtl/sram_wr_fifo.sv
// Synchronous write-request FIFO. Ready and level are registered; a freshly
// pushed entry becomes visible at the head one cycle later (no bypass).
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  sram_wr_req_t                 i_push_data,
    output logic                         o_ready,
    input  logic                         i_pop,
    output sram_wr_req_t                 o_head,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    sram_wr_req_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = i_push && ready_q;
    assign pop_ok  = i_pop && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Ready follows the post-update level, so a pop at full only
        // re-opens the FIFO on the following cycle.
        ready_d = (level_d != LVL_W'(DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= i_push_data;
    end

    assign o_head  = mem[rd_ptr_q];
    assign o_ready = ready_q;
    assign o_empty = (level_q == '0);
    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_level = level_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: decoder reads win in active video, buffered
// encoder writes win in blanking. SRAM_ARB_STATS_EN adds stall/full counters.
module sram_port_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_COUNT,
    parameter int DATA_W       = SRAM_DATA_WIDTH,
    parameter int WFIFO_DEPTH  = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sram_port_arbiter_if.slave  bus,
`ifdef SRAM_ARB_STATS_EN
    output logic [31:0]         o_rd_stall_cnt,
    output logic [31:0]         o_wr_full_cnt,
`endif
    output logic [ADDR_W-1:0]   o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0]   io_SRAM_DQ,
    output logic                o_SRAM_WE_N
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    sram_arb_state_t   state_q, state_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    sram_wr_req_t      push_req;
    sram_wr_req_t      head;
    logic              fifo_ready, fifo_empty, fifo_full;
    logic              rd_gnt, wr_pop, forced, rd_blocked;

    // Request record is sized by the package geometry, matching the default
    // ADDR_W/DATA_W.
    assign push_req.addr = bus.i_wr_addr;
    assign push_req.data = bus.i_wr_data;

    sram_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (bus.i_wr_valid),
        .i_push_data (push_req),
        .o_ready     (fifo_ready),
        .i_pop       (wr_pop),
        .o_head      (head),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_level     (bus.o_wfifo_level)
    );

    always_comb begin
        state_d      = state_q;
        rd_gnt       = 1'b0;
        wr_pop       = 1'b0;
        forced       = fifo_full && (starve_cnt_q == SC_W'(STARVE_LIMIT));
        // The bus cycle after a write must not be a read; hold reads off while
        // a write is on the pins and during the turnaround cycle itself.
        rd_blocked   = (state_q == S_WRITE) || (state_q == S_TURN);

        if (forced) begin
            wr_pop = 1'b1;
        end else if (bus.i_frame_blank) begin
            if (!fifo_empty)                      wr_pop = 1'b1;
            else if (bus.i_rd_req && !rd_blocked) rd_gnt = 1'b1;
        end else begin
            if (bus.i_rd_req) begin
                if (!rd_blocked) rd_gnt = 1'b1;
            end else if (!fifo_empty) begin
                wr_pop = 1'b1;
            end
        end

        if (wr_pop)                 state_d = S_WRITE;
        else if (rd_gnt)            state_d = S_READ;
        else if (state_q == S_WRITE) state_d = S_TURN;
        else                        state_d = S_IDLE;

        if (wr_pop)          starve_cnt_d = '0;
        else if (!fifo_full) starve_cnt_d = '0;
        else if (starve_cnt_q != SC_W'(STARVE_LIMIT))
                             starve_cnt_d = starve_cnt_q + SC_W'(1);
        else                 starve_cnt_d = starve_cnt_q;

        addr_d  = addr_q;
        dq_d    = dq_q;
        we_n_d  = !wr_pop;
        dq_oe_d = wr_pop;
        if (wr_pop) begin
            addr_d = head.addr;
            dq_d   = head.data;
        end else if (rd_gnt) begin
            addr_d = bus.i_rd_addr;
        end

        rd_valid_d = (state_q == S_READ);
        rd_data_d  = rd_valid_d ? io_SRAM_DQ : rd_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            dq_q         <= '0;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            dq_q         <= dq_d;
            dq_oe_q      <= dq_oe_d;
            we_n_q       <= we_n_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = we_n_q;
    assign io_SRAM_DQ  = dq_oe_q ? dq_q : {DATA_W{1'bz}};

    assign bus.o_rd_gnt        = rd_gnt;
    assign bus.o_rd_data       = rd_data_q;
    assign bus.o_rd_data_valid = rd_valid_q;
    assign bus.o_wr_ready      = fifo_ready;
    assign bus.o_starve        = forced;

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] rd_stall_q, rd_stall_d;
    logic [31:0] wr_full_q, wr_full_d;

    always_comb begin
        rd_stall_d = rd_stall_q;
        wr_full_d  = wr_full_q;
        if (bus.i_rd_req && !rd_gnt && (rd_stall_q != '1))
            rd_stall_d = rd_stall_q + 32'd1;
        if (bus.i_wr_valid && !fifo_ready && (wr_full_q != '1))
            wr_full_d = wr_full_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_stall_q <= '0;
            wr_full_q  <= '0;
        end else begin
            rd_stall_q <= rd_stall_d;
            wr_full_q  <= wr_full_d;
        end
    end

    assign o_rd_stall_cnt = rd_stall_q;
    assign o_wr_full_cnt  = wr_full_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus queues expected reads and
// writes, a negedge monitor checks every data-valid pulse and write cycle.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] full_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] rexp [$];
    logic [35:0] wexp [$];
    logic [15:0] t2_dat [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16), .WFIFO_DEPTH(8)) bus ();

    sram_port_arbiter #(
        .ADDR_W(20), .DATA_W(16), .WFIFO_DEPTH(8), .STARVE_LIMIT(64)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .bus            (bus),
`ifdef SRAM_ARB_STATS_EN
        .o_rd_stall_cnt (stall_cnt),
        .o_wr_full_cnt  (full_cnt),
`endif
        .o_SRAM_ADDR    (sram_addr),
        .io_SRAM_DQ     (sram_dq),
        .o_SRAM_WE_N    (sram_we_n)
    );

    // Asynchronous SRAM with OE tied active: drives addr[15:0] while WE_N high.
    assign sram_dq = sram_we_n ? sram_addr[15:0] : 16'hzzzz;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_rd_data_valid) begin
            if (rexp.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", bus.o_rd_data, rexp.pop_front());
        end
        if (!sram_we_n) begin
            if (wexp.size() == 0) chk("wr_unexpected", {sram_addr, sram_dq}, 0);
            else chk("wr_addr_data", {sram_addr, sram_dq}, wexp.pop_front());
        end
    end

    task automatic smp();
        @(negedge clk);
        #1;
        if (bus.i_wr_valid && bus.o_wr_ready) wexp.push_back({bus.i_wr_addr, bus.i_wr_data});
        if (bus.o_rd_gnt) rexp.push_back(bus.i_rd_addr[15:0]);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_rd_req   = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_frame_blank = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        idle_inputs();
        while ((wexp.size() != 0 || rexp.size() != 0 || bus.o_wfifo_level != 0) && n < max_cyc) begin
            smp();
            adv();
            n++;
        end
        chk("drain_in_time", n < max_cyc, 1);
    endtask

    initial begin
        bus.i_frame_blank = 1'b0;
        bus.i_rd_req      = 1'b0;
        bus.i_rd_addr     = '0;
        bus.i_wr_valid    = 1'b0;
        bus.i_wr_addr     = '0;
        bus.i_wr_data     = '0;

        // Reset state
        adv();
        adv();
        smp();
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        chk("rst_rd_valid", bus.o_rd_data_valid, 0);
        chk("rst_starve", bus.o_starve, 0);
        chk("rst_level", bus.o_wfifo_level, 0);
        chk("rst_ready", bus.o_wr_ready, 1);
        rst = 1'b0;
        adv();

        // Four pipelined reads in active video
        for (int k = 0; k < 7; k++) begin
            bus.i_frame_blank = 1'b0;
            bus.i_rd_req  = (k < 4);
            bus.i_rd_addr = 20'h00010 + 20'(k);
            smp();
            chk($sformatf("t1_gnt[%0d]", k), bus.o_rd_gnt, (k < 4));
            chk($sformatf("t1_valid[%0d]", k), bus.o_rd_data_valid, (k >= 2 && k <= 5));
            chk($sformatf("t1_we_n[%0d]", k), sram_we_n, 1);
            adv();
        end

        // Blanking: three writes beat a held read, then turnaround
        for (int k = 0; k < 7; k++) begin
            bus.i_frame_blank = 1'b1;
            bus.i_rd_req  = 1'b1;
            bus.i_rd_addr = 20'h00200;
            bus.i_wr_valid = (k < 3);
            bus.i_wr_addr = 20'h00100 + 20'(k);
            bus.i_wr_data = (k < 3) ? t2_dat[k] : 16'h0;
            smp();
            chk($sformatf("t2_gnt[%0d]", k), bus.o_rd_gnt, (k == 0 || k == 6));
            chk($sformatf("t2_we_n[%0d]", k), sram_we_n, !(k >= 2 && k <= 4));
            chk($sformatf("t2_level[%0d]", k), bus.o_wfifo_level, (k >= 1 && k <= 3) ? 1 : 0);
            chk($sformatf("t2_ready[%0d]", k), bus.o_wr_ready, 1);
            adv();
        end
        drain(20);

        // Active video: reads hold the bus until a full FIFO starves
        bus.i_frame_blank = 1'b0;
        bus.i_rd_req      = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i_rd_addr  = 20'h00300 + 20'(k);
            bus.i_wr_valid = 1'b1;
            bus.i_wr_addr  = 20'h00400 + 20'(k);
            bus.i_wr_data  = 16'h1000 + 16'(k);
            smp();
            chk($sformatf("t3_fill_ready[%0d]", k), bus.o_wr_ready, 1);
            chk($sformatf("t3_fill_gnt[%0d]", k), bus.o_rd_gnt, 1);
            adv();
        end
        bus.i_wr_valid = 1'b0;
        for (int j = 0; j < 70; j++) begin
            bus.i_rd_addr = 20'h00340 + 20'(j);
            smp();
            chk($sformatf("t3_starve[%0d]", j), bus.o_starve, (j == 64));
            chk($sformatf("t3_gnt[%0d]", j), bus.o_rd_gnt, !(j >= 64 && j <= 66));
            chk($sformatf("t3_level[%0d]", j), bus.o_wfifo_level, (j <= 64) ? 8 : 7);
            chk($sformatf("t3_ready[%0d]", j), bus.o_wr_ready, (j > 64));
            chk($sformatf("t3_we_n[%0d]", j), sram_we_n, (j != 65));
            adv();
        end

        // Push rejected at full while a pop happens; ready returns a cycle later
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 20'h00500;
        bus.i_wr_data  = 16'hD00D;
        smp();
        chk("t4_r0_ready", bus.o_wr_ready, 1);
        chk("t4_r0_level", bus.o_wfifo_level, 7);
        adv();
        bus.i_frame_blank = 1'b1;
        bus.i_rd_req  = 1'b0;
        bus.i_wr_addr = 20'h00501;
        bus.i_wr_data = 16'hE00E;
        smp();
        chk("t4_r1_ready", bus.o_wr_ready, 0);
        chk("t4_r1_level", bus.o_wfifo_level, 8);
        adv();
        smp();
        chk("t4_r2_ready", bus.o_wr_ready, 1);
        chk("t4_r2_level", bus.o_wfifo_level, 7);
        adv();
        drain(40);

        // Reset during a write burst with five entries queued
        bus.i_frame_blank = 1'b0;
        bus.i_rd_req      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.i_rd_addr  = 20'h00600 + 20'(k);
            bus.i_wr_valid = 1'b1;
            bus.i_wr_addr  = 20'h00700 + 20'(k);
            bus.i_wr_data  = 16'h2000 + 16'(k);
            smp();
            chk($sformatf("t5_fill_ready[%0d]", k), bus.o_wr_ready, 1);
            adv();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            smp();
            adv();
        end
        rst = 1'b1;
        smp();
        chk("t5_burst_we_n", sram_we_n, 0);
        adv();
        rst = 1'b0;
        smp();
        chk("t5_rst_we_n", sram_we_n, 1);
        chk("t5_rst_level", bus.o_wfifo_level, 0);
        chk("t5_rst_valid", bus.o_rd_data_valid, 0);
        chk("t5_rst_ready", bus.o_wr_ready, 1);
        chk("t5_aborted_writes", wexp.size(), 2);
        wexp.delete();
        chk("t5_reads_left", rexp.size(), 0);
        adv();
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("t5_no_stale[%0d]", k), sram_we_n, 1);
            adv();
        end

        // Blanking with a non-empty FIFO stalls the decoder for 10 cycles
        bus.i_frame_blank = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 20'h00800;
        bus.i_wr_data  = 16'h3000;
        smp();
        adv();
        for (int k = 1; k <= 10; k++) begin
            bus.i_rd_req   = 1'b1;
            bus.i_rd_addr  = 20'h00900 + 20'(k);
            bus.i_wr_addr  = 20'h00800 + 20'(k);
            bus.i_wr_data  = 16'h3000 + 16'(k);
            smp();
            chk($sformatf("t6_gnt[%0d]", k), bus.o_rd_gnt, 0);
            chk($sformatf("t6_we_n[%0d]", k), sram_we_n, (k == 1));
            adv();
        end
        bus.i_rd_req   = 1'b0;
        bus.i_wr_valid = 1'b0;
        smp();
`ifdef SRAM_ARB_STATS_EN
        chk("t6_stall_cnt", stall_cnt, 10);
        chk("t6_full_cnt", full_cnt, 0);
`endif
        adv();
        drain(20);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        smp();
`ifdef SRAM_ARB_STATS_EN
        chk("t6_stall_cnt_rst", stall_cnt, 0);
`endif
        chk("t6_level_rst", bus.o_wfifo_level, 0);
        adv();

        chk("end_wexp_empty", wexp.size(), 0);
        chk("end_rexp_empty", rexp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sole owner of the single-port external SRAM; shares it between the frame encoder (write requester) and the frame decoder (read requester).
- Buffers encoder writes in a small FIFO and gives decoder reads priority during active video. Writes take priority during blanking.
- Inserts a bus-turnaround cycle on write-to-read and drives the SRAM pins from registers.

Parameters:
- ADDR_W, 20, SRAM address width (sram_pkg::SRAM_ADDR_COUNT)
- DATA_W, 16, SRAM data width (sram_pkg::SRAM_DATA_WIDTH)
- WFIFO_DEPTH, 8, write FIFO entries, power of two, at least 2
- STARVE_LIMIT, 64, consecutive cycles a full FIFO may go unserved before one write is forced

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_frame_blank  in  1  high during VGA blanking; selects write priority
- i_rd_req  in  1  decoder read request
- i_rd_addr  in  ADDR_W  read address
- o_rd_gnt  out  1  combinational; request accepted this cycle
- o_rd_data  out  DATA_W  read data
- o_rd_data_valid  out  1  o_rd_data valid, one-cycle pulse
- i_wr_valid  in  1  encoder write valid
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_W  write data
- o_wr_ready  out  1  FIFO not full (registered)
- o_wfifo_level  out  $clog2(WFIFO_DEPTH+1)  FIFO occupancy
- o_starve  out  1  one-cycle pulse when a forced write is issued
- o_SRAM_ADDR  out  ADDR_W  SRAM address
- io_SRAM_DQ  inout  DATA_W  SRAM data bus
- o_SRAM_WE_N  out  1  SRAM write enable, active low

Behaviour:
- Reset values:
  - o_SRAM_WE_N=1, DQ released (Z), o_SRAM_ADDR=0.
  - o_rd_data=0, o_rd_data_valid=0, o_starve=0, o_wfifo_level=0, o_wr_ready=1.
  - FSM=S_IDLE, starve counter=0, FIFO flushed.
- Reset mid-operation: any in-flight read is dropped with no valid pulse; any in-flight write is aborted (WE_N high at the next edge).
- FIFO push: on i_wr_valid && o_wr_ready. o_wr_ready = !full, registered.
  - A pop in the same cycle does not raise ready until the next cycle.
  - There is no push-to-pop bypass: an entry becomes eligible the cycle after it is pushed.
- Arbitration, once per cycle, over candidates read (i_rd_req) and write (FIFO non-empty):
  - i_frame_blank=0: read wins.
  - i_frame_blank=1: write wins.
  - Forced write: if the FIFO is full and no write has issued for STARVE_LIMIT consecutive cycles, the next cycle issues a write regardless. o_rd_gnt=0 that cycle, o_starve pulses, and the counter clears on any issued write.
- Turnaround: a read may not issue in the cycle immediately after a write cycle.
  - In that cycle the FSM sits in S_TURN, o_rd_gnt=0 and DQ is Z.
  - Read-to-write needs no turnaround.
- FSM states:
  - S_IDLE: no op issued.
  - S_READ: address driven, WE_N=1, DQ=Z.
  - S_WRITE: address and data driven, WE_N=0.
  - S_TURN: entered only after S_WRITE when the winner is a read or nothing; otherwise S_WRITE repeats.
  - All other transitions follow the arbitration winner.
- Read timing:
  - Request accepted at cycle N (o_rd_gnt=1).
  - SRAM address registered and driven during N+1; DQ sampled at the end of N+1.
  - o_rd_data and o_rd_data_valid appear in N+2. Fixed latency 2; fully pipelined, one read per cycle.
- Write timing: popped at N, driven during N+1. Back-to-back writes keep WE_N low with the address changing each cycle.
- Out-of-range addresses are not checked; the address is passed through unchanged.
- o_wfifo_level is registered and updated on push/pop the same edge.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs o_rd_stall_cnt[31:0] (cycles with i_rd_req && !o_rd_gnt) and o_wr_full_cnt[31:0] (cycles with i_wr_valid && !o_wr_ready).
  - Both counters saturate at all-ones and clear on i_rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- sram_pkg:
  - Holds SRAM_ADDR_COUNT and SRAM_DATA_WIDTH.
  - Gains typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} sram_arb_state_t and struct sram_wr_req_t {addr, data}.
- Sub-module sram_wr_fifo:
  - Synchronous FIFO of sram_wr_req_t with full/empty/level.
  - Synchronous active-high reset on i_clk/i_rst.

Test Plan:
- Reset, then i_rd_req=1 with addr 0x00010 for 4 cycles, blank=0, SRAM model returns addr[15:0] → o_rd_data_valid high for 4 consecutive cycles starting 2 cycles after the first gnt; data 0x0010..0x0013; WE_N stays 1.
- blank=1; push 3 writes (0x100→0xAAAA, 0x101→0xBBBB, 0x102→0xCCCC) while i_rd_req=1 → 3 consecutive WE_N-low cycles with those addr/data, then 1 S_TURN cycle (gnt=0, DQ=Z), then a read grant.
- blank=0; i_rd_req held high; push 8 writes → FIFO fills (level=8, ready=0); after 64 cycles full, one write issues, gnt=0 that cycle, o_starve pulses once, level=7.
- Push at full in the same cycle as a pop → push rejected; ready=1 only in the next cycle; no data lost or duplicated (compare against a scoreboard).
- Assert i_rst during a write burst with 5 entries queued → next edge WE_N=1, level=0, o_rd_data_valid=0, no stale write appears after reset release.
- SRAM_ARB_STATS_EN defined, blank=1, FIFO kept non-empty, i_rd_req high for 10 cycles → o_rd_stall_cnt=10; reset → 0.
